latency_pattern_gen: RTL and testbench
======================================

LATENCY_PATTERN_GEN -- requirements
Module: latency_pattern_gen

Interface
REQ-001 The block SHALL have parameters (name, default, meaning): H_ACTIVE 1280 active pixels; H_FRONT 110; H_SYNC 40; H_BACK 220; V_ACTIVE 720 active lines; V_FRONT 5; V_SYNC 5; V_BACK 20; HSYNC_POL 1 (1 = active-high); VSYNC_POL 1; FLASH_FRAMES 1 (frames of white per trigger, >=1).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Ports (name direction width meaning): clock in 1 pixel clock; reset in 1 async active-high reset; mode in 2 pattern select; trigger in 1 flash request, single-cycle pulse; video_data out 24 RGB888 pixel; video_hsync out 1; video_vsync out 1; video_de out 1 data enable; blink out 1 high during flash frames; frame_start out 1 pulse; busy out 1 flash pending or active.

Function
REQ-004 The H counter SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of the four H parameters); V SHALL advance on H wrap, 0..V_TOTAL-1, then wrap to 0; widths = $clog2 of the totals.
REQ-005 All video outputs SHALL be registered, lagging the counters by exactly 1 cycle.
REQ-006 video_de SHALL be 1 iff h < H_ACTIVE and v < V_ACTIVE.
REQ-007 hsync SHALL be at active level iff H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC; vsync likewise on v; otherwise at inactive level (!POL).
REQ-008 frame_start SHALL pulse for 1 cycle, aligned with the output of pixel (0,0).
REQ-009 video_data SHALL be 0 whenever video_de = 0.
REQ-010 Patterns: mode 0 = black; mode 1 = 8 colour bars FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000, bar width H_ACTIVE/8, bar index saturating at 7; mode 2 = grey ramp {h[7:0]} in R, G and B; mode 3 = grey level from frame counter [7:0], incremented at each frame start.
REQ-011 mode SHALL be sampled only at h=0, v=0; a mid-frame change SHALL take effect at the next frame.
REQ-012 FSM states: IDLE, ARMED, FLASH.
REQ-013 IDLE -> ARMED on trigger=1.
REQ-014 ARMED -> FLASH at the next h=0, v=0, loading flash_cnt = FLASH_FRAMES.
REQ-015 In FLASH, flash_cnt SHALL decrement at each frame start; FLASH -> IDLE at the frame start where flash_cnt = 1.
REQ-016 trigger SHALL be ignored in ARMED and in FLASH (no queueing).
REQ-017 Triggers coincident with h=0, v=0 while in IDLE SHALL enter ARMED, with the flash starting at the following frame.
REQ-018 During FLASH, active pixels SHALL be FFFFFF regardless of mode.
REQ-019 blink SHALL be 1 for exactly the output cycles of the flash frames, frame-aligned with frame_start.
REQ-020 busy SHALL be 1 whenever the state is not IDLE, registered, and asserted the cycle after an accepted trigger.

Reset
REQ-021 Reset SHALL act asynchronously: counters 0, state IDLE, flash_cnt 0, frame counter 0, sampled mode 0.
REQ-022 While in reset, outputs SHALL be: video_data 0, video_de 0, hsync/vsync inactive level, frame_start 0, blink 0, busy 0.
REQ-023 Reset asserted mid-flash SHALL abort the flash; after release, the first output cycle SHALL be pixel (0,0) with frame_start=1.

Structure
REQ-024 Package latency_checker_pkg SHALL hold the mode enum (MODE_BLACK, MODE_BARS, MODE_RAMP, MODE_FRAME), the state enum, and the 8 bar colour constants.
REQ-025 Sub-module video_timing_counter (parametrised H/V counters plus raw de/sync/frame_start) SHALL be instantiated once; pattern mux, FSM and output registers live in the top.

Verification (sim params: H 16/2/2/2 = 22, V 4/1/1/1 = 7, frame = 154 cycles, FLASH_FRAMES 2)
REQ-026 Release reset -> frame_start at the 1st output cycle, then every 154 cycles; per frame, video_de high in 4 runs of 16 cycles, each run 22 cycles apart.
REQ-027 Free-run -> hsync active for 2 cycles starting 18 cycles after each de rise; vsync active for 22 cycles starting 110 cycles after frame_start.
REQ-028 mode=1 -> pixel pairs 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000; blanking 000000.
REQ-029 trigger mid-frame -> busy=1 next cycle; blink=1 with FFFFFF active pixels for the next 2 whole frames, then pattern resumes and busy=0; a second trigger during the flash has no effect.
REQ-030 mode 1->2 mid-frame -> bars until frame end, ramp 00..0F from the next frame_start.
REQ-031 reset pulse during FLASH -> all outputs at reset values immediately, busy=0; after release, normal pattern with no flash.

Source files
------------

// File: rtl/latency_checker_pkg.sv
// latency_checker_pkg: shared enums and colour-bar constants for latency_pattern_gen.
package latency_checker_pkg;
    typedef enum logic [1:0] {MODE_BLACK, MODE_BARS, MODE_RAMP, MODE_FRAME} mode_t;
    typedef enum logic [1:0] {IDLE, ARMED, FLASH} state_t;
    // index 0 is the leftmost bar
    localparam logic [7:0][23:0] BAR_COLORS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };
    function automatic logic [23:0] bar_color(input logic [2:0] i);
        return BAR_COLORS[i];
    endfunction
endpackage

// File: rtl/video_timing_counter.sv
// video_timing_counter: free-running H/V raster counters with raw de, sync and frame-start flags.
module video_timing_counter #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FRONT  = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FRONT  = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20,
    parameter int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    parameter int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    parameter int HW       = $clog2(H_TOTAL),
    parameter int VW       = $clog2(V_TOTAL)
) (
    input  logic          clock,
    input  logic          reset,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == HW'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == VW'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign de          = h < HW'(H_ACTIVE) && v < VW'(V_ACTIVE);
    assign hsync       = h >= HW'(H_ACTIVE + H_FRONT) && h < HW'(H_ACTIVE + H_FRONT + H_SYNC);
    assign vsync       = v >= VW'(V_ACTIVE + V_FRONT) && v < VW'(V_ACTIVE + V_FRONT + V_SYNC);
    assign frame_start = h == '0 && v == '0;
endmodule

// File: rtl/latency_pattern_gen.sv
// latency_pattern_gen: video test-pattern source with a triggerable white flash for latency measurement.
module latency_pattern_gen
    import latency_checker_pkg::*;
#(
    parameter int H_ACTIVE     = 1280,
    parameter int H_FRONT      = 110,
    parameter int H_SYNC       = 40,
    parameter int H_BACK       = 220,
    parameter int V_ACTIVE     = 720,
    parameter int V_FRONT      = 5,
    parameter int V_SYNC       = 5,
    parameter int V_BACK       = 20,
    parameter int HSYNC_POL    = 1,
    parameter int VSYNC_POL    = 1,
    parameter int FLASH_FRAMES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  mode,
    input  logic        trigger,
    output logic [23:0] video_data,
    output logic        video_hsync,
    output logic        video_vsync,
    output logic        video_de,
    output logic        blink,
    output logic        frame_start,
    output logic        busy
);
    localparam int   H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int   V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int   HW      = $clog2(H_TOTAL);
    localparam int   VW      = $clog2(V_TOTAL);
    localparam int   FW      = $clog2(FLASH_FRAMES + 1);
    localparam int   BAR_W   = H_ACTIVE / 8 > 0 ? H_ACTIVE / 8 : 1;
    localparam logic HS_ACT  = HSYNC_POL != 0;
    localparam logic VS_ACT  = VSYNC_POL != 0;

    logic [HW-1:0] h, bar_raw;
    logic [VW-1:0] v;
    logic          de, hs, vs, start, flash_on;
    logic [2:0]    bar;
    logic [7:0]    frame_cnt, grey;
    logic [FW-1:0] flash_cnt;
    logic [23:0]   pixel;
    mode_t         mode_q, cur_mode;
    state_t        state;

    video_timing_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) timing (
        .clock(clock), .reset(reset), .h(h), .v(v),
        .de(de), .hsync(hs), .vsync(vs), .frame_start(start)
    );

    // At the first pixel of a frame the live mode/state decide that frame's content
    assign cur_mode = start ? mode_t'(mode) : mode_q;
    assign grey     = frame_cnt + 8'(start);
    assign flash_on = start ? (state == ARMED || (state == FLASH && flash_cnt != FW'(1)))
                            : state == FLASH;
    assign bar_raw  = h / HW'(BAR_W);
    assign bar      = bar_raw > HW'(7) ? 3'd7 : bar_raw[2:0];
    assign pixel    = !de                     ? 24'h000000 :
                      flash_on                ? 24'hFFFFFF :
                      cur_mode == MODE_BARS   ? bar_color(bar) :
                      cur_mode == MODE_RAMP   ? {3{8'(h)}} :
                      cur_mode == MODE_FRAME  ? {3{grey}} : 24'h000000;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            flash_cnt <= '0;
            frame_cnt <= '0;
            mode_q    <= MODE_BLACK;
        end else begin
            if (start) begin
                mode_q    <= cur_mode;
                frame_cnt <= grey;
            end
            case (state)
                IDLE:
                    if (trigger) begin
                        state <= ARMED;
                        busy  <= 1'b1;
                    end
                ARMED:
                    if (start) begin
                        state     <= FLASH;
                        flash_cnt <= FW'(FLASH_FRAMES);
                    end
                FLASH:
                    if (start) begin
                        flash_cnt <= flash_cnt - 1'b1;
                        if (flash_cnt == FW'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            video_data  <= '0;
            video_de    <= 1'b0;
            video_hsync <= !HS_ACT;
            video_vsync <= !VS_ACT;
            frame_start <= 1'b0;
            blink       <= 1'b0;
        end else begin
            video_data  <= pixel;
            video_de    <= de;
            video_hsync <= HS_ACT ? hs : !hs;
            video_vsync <= VS_ACT ? vs : !vs;
            frame_start <= start;
            blink       <= flash_on;
        end
    end
endmodule

// File: tb/tb_latency_pattern_gen.sv
// tb_latency_pattern_gen: randomized check of latency_pattern_gen against a frame-arithmetic reference model.
module tb_latency_pattern_gen;
    localparam int HT = 22;
    localparam int FT = 154;

    logic        clock = 1'b0, reset = 1'b0, trigger = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] video_data;
    logic        video_hsync, video_vsync, video_de, blink, frame_start, busy;

    int checks = 0, passed = 0;
    // k: output cycle index since reset release; busy_end: first cycle busy is low again
    int k = 0, busy_end = -1, flash_f = -10;
    logic [1:0] fm = 2'd0, rmode = 2'd0;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    always #5 clock = ~clock;

    latency_pattern_gen #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .FLASH_FRAMES(2)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode), .trigger(trigger),
        .video_data(video_data), .video_hsync(video_hsync), .video_vsync(video_vsync),
        .video_de(video_de), .blink(blink), .frame_start(frame_start), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    endtask

    task automatic check_reset_outputs();
        check("rst_data", video_data, 0);
        check("rst_de", video_de, 0);
        check("rst_hsync", video_hsync, 0);
        check("rst_vsync", video_vsync, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_blink", blink, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic cycle(input logic [1:0] m, input logic trg);
        int p, f, hh, vv;
        logic de_e, bl;
        logic [23:0] d;
        mode = m;
        trigger = trg;
        @(posedge clock);
        p  = k % FT;
        f  = k / FT;
        hh = p % HT;
        vv = p / HT;
        if (p == 0) fm = m;
        if (trg && k > busy_end) begin
            flash_f  = f + 1;
            busy_end = (f + 3) * FT;
        end
        de_e = hh < 16 && vv < 4;
        bl   = f == flash_f || f == flash_f + 1;
        d = !de_e    ? 24'h0 :
            bl       ? 24'hFFFFFF :
            fm == 1  ? bars[hh / 2 > 7 ? 7 : hh / 2] :
            fm == 2  ? {3{8'(hh)}} :
            fm == 3  ? {3{8'(f + 1)}} : 24'h0;
        #1;
        check("de", video_de, de_e);
        check("hsync", video_hsync, hh >= 18 && hh < 20);
        check("vsync", video_vsync, vv == 5);
        check("frame_start", frame_start, p == 0);
        check("blink", blink, bl);
        check("busy", busy, k < busy_end);
        check("data", video_data, d);
        k++;
    endtask

    task automatic reset_pulse();
        trigger = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        repeat (3) @(posedge clock);
        #1 check_reset_outputs();
        @(negedge clock);
        reset = 1'b0;
        k = 0;
        busy_end = -1;
        flash_f = -10;
        fm = 2'd0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (2 * FT) cycle(2'd0, 1'b0);
        repeat (70) cycle(2'd0, 1'b0);
        repeat (2 * FT) cycle(2'd1, 1'b0);
        repeat (80) cycle(2'd1, 1'b0);
        repeat (FT) cycle(2'd2, 1'b0);
        repeat (FT) cycle(2'd3, 1'b0);
        // mid-frame trigger, then a second one while the flash is pending/active
        cycle(2'd1, 1'b1);
        repeat (200) cycle(2'd1, 1'b0);
        cycle(2'd1, 1'b1);
        repeat (4 * FT) cycle(2'd1, 1'b0);
        // trigger landing exactly on the first pixel of a frame
        while (k % FT != 0) cycle(2'd2, 1'b0);
        cycle(2'd2, 1'b1);
        repeat (4 * FT) cycle(2'd2, 1'b0);
        // reset in the middle of a flash
        cycle(2'd1, 1'b1);
        repeat (FT + 30) cycle(2'd1, 1'b0);
        reset_pulse();
        repeat (2 * FT) cycle(2'd1, 1'b0);
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) rmode = 2'($urandom_range(0, 3));
            cycle(rmode, $urandom_range(0, 399) == 0);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
